// File: rtl/odd_ctrl_pkg.sv
// Shared types, default latencies and helpers for the odd-pipe issue controller.
package odd_ctrl_pkg;

  typedef enum logic [1:0] {
    PERM  = 2'd0,
    LS    = 2'd1,
    BR    = 2'd2,
    UNDEF = 2'd3
  } unit_e;

  localparam int RES_DEPTH    = 7;
  localparam int PERM_LAT_DEF = 4;
  localparam int LS_LAT_DEF   = 6;
  localparam int BR_LAT_DEF   = 2;
  localparam int REG_AW       = 7;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rt_addr;
    logic              reg_write;
    unit_e             unit;
  } resv_entry_t;

  function automatic int unit_lat(input unit_e u, input int perm_lat, input int ls_lat,
                                  input int br_lat);
    int lat;
    case (u)
      PERM:    lat = perm_lat;
      LS:      lat = ls_lat;
      BR:      lat = br_lat;
      default: lat = 0;
    endcase
    return lat;
  endfunction

  // True when a pending register write collides with any used source operand.
  function automatic logic src_hit(input resv_entry_t e, input logic [REG_AW-1:0] ra,
                                   input logic [REG_AW-1:0] rb, input logic [REG_AW-1:0] rc,
                                   input logic [2:0] used);
    return e.valid && e.reg_write &&
           ((used[2] && (e.rt_addr == ra)) ||
            (used[1] && (e.rt_addr == rb)) ||
            (used[0] && (e.rt_addr == rc)));
  endfunction

endpackage

// File: rtl/odd_issue_ctrl_resv.sv
// Reservation shift register: slot k holds the result due k cycles from now;
// slot 0 is the registered writeback stage.
module odd_resv_shift
  import odd_ctrl_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DEPTH-1:0]  ins_slot,
  input  resv_entry_t       ins_entry,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  input  logic [REG_AW-1:0] rc_addr,
  input  logic [2:0]        src_used,
  output logic [DEPTH-1:0]  occ,
  output logic [DEPTH-1:0]  match,
  output resv_entry_t       head,
  output logic              busy
);

  resv_entry_t slot_r     [DEPTH];
  resv_entry_t slot_nxt_s [DEPTH];
  logic        any_nxt_s;
  logic        busy_r;

  // Shift toward writeback and drop the new entry into its target slot.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (ins_slot[k]) begin
        slot_nxt_s[k] = ins_entry;
      end else begin
        slot_nxt_s[k] = slot_r[k+1];
      end
    end
    if (ins_slot[DEPTH-1]) begin
      slot_nxt_s[DEPTH-1] = ins_entry;
    end else begin
      slot_nxt_s[DEPTH-1] = '0;
    end
    any_nxt_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_nxt_s = any_nxt_s | slot_nxt_s[k].valid;
    end
  end

  // Slot storage and registered occupancy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= '0;
      end
      busy_r <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= slot_nxt_s[k];
      end
      busy_r <= any_nxt_s;
    end
  end

  // Per-slot occupancy and source-operand match vectors.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      occ[k]   = slot_r[k].valid;
      match[k] = src_hit(slot_r[k], ra_addr, rb_addr, rc_addr, src_used);
    end
  end

  assign head = slot_r[0];
  assign busy = busy_r;

endmodule

// File: rtl/odd_issue_ctrl.sv
// Odd-pipe issue controller: accept/stall logic, unit go pulses and writeback slotting.
// Define ODD_SCOREBOARD_EN to enable the RAW hazard interlock.
module odd_issue_ctrl
  import odd_ctrl_pkg::*;
#(
  parameter int DEPTH    = RES_DEPTH,
  parameter int PERM_LAT = PERM_LAT_DEF,
  parameter int LS_LAT   = LS_LAT_DEF,
  parameter int BR_LAT   = BR_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  unit,
  input  logic [6:0]  rt_addr,
  input  logic        reg_write,
  input  logic [6:0]  ra_addr,
  input  logic [6:0]  rb_addr,
  input  logic [6:0]  rc_addr,
  input  logic [2:0]  src_used,
  output logic        perm_go,
  output logic        ls_go,
  output logic        br_go,
  output logic        wb_valid,
  output logic [6:0]  rt_addr_wb,
  output logic        reg_write_wb,
  output logic [1:0]  wb_unit,
  output logic        illegal_op,
  output logic        busy
);

  unit_e            unit_s;
  int               lat_s;
  logic             conflict_s;
  logic             hazard_s;
  logic             undef_s;
  logic             ready_s;
  logic             accept_s;
  logic [DEPTH-1:0] ins_slot_s;
  logic [DEPTH-1:0] occ_s;
  logic [DEPTH-1:0] match_s;
  resv_entry_t      ins_entry_s;
  resv_entry_t      head_s;
  logic             busy_s;
  logic             perm_go_r;
  logic             ls_go_r;
  logic             br_go_r;
  logic             illegal_r;

  odd_resv_shift #(.DEPTH(DEPTH)) u_resv (
    .clk       (clk),
    .reset     (reset),
    .ins_slot  (ins_slot_s),
    .ins_entry (ins_entry_s),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .rc_addr   (rc_addr),
    .src_used  (src_used),
    .occ       (occ_s),
    .match     (match_s),
    .head      (head_s),
    .busy      (busy_s)
  );

  // Accept decision: slot k currently owns writeback cycle now+k.
  always_comb begin
    unit_s     = unit_e'(unit);
    lat_s      = unit_lat(unit_s, PERM_LAT, LS_LAT, BR_LAT);
    undef_s    = (unit_s == UNDEF);
    conflict_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == lat_s) begin
        conflict_s = occ_s[k];
      end else begin
        conflict_s = conflict_s;
      end
    end
`ifdef ODD_SCOREBOARD_EN
    hazard_s = |match_s;
`else
    hazard_s = 1'b0 & (|match_s);
`endif
    ready_s  = !reset && (undef_s || (!conflict_s && !hazard_s));
    accept_s = issue_valid && ready_s;
    for (int k = 0; k < DEPTH; k++) begin
      ins_slot_s[k] = accept_s && !undef_s && (k == lat_s - 1);
    end
    ins_entry_s = '{valid: 1'b1, rt_addr: rt_addr, reg_write: reg_write, unit: unit_s};
  end

  // One-cycle start and illegal-op pulses following an accepted issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      perm_go_r <= 1'b0;
      ls_go_r   <= 1'b0;
      br_go_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      perm_go_r <= accept_s && (unit_s == PERM);
      ls_go_r   <= accept_s && (unit_s == LS);
      br_go_r   <= accept_s && (unit_s == BR);
      illegal_r <= accept_s && undef_s;
    end
  end

  assign issue_ready  = ready_s;
  assign perm_go      = perm_go_r;
  assign ls_go        = ls_go_r;
  assign br_go        = br_go_r;
  assign illegal_op   = illegal_r;
  assign wb_valid     = head_s.valid;
  assign rt_addr_wb   = head_s.rt_addr;
  assign reg_write_wb = head_s.reg_write;
  assign wb_unit      = head_s.unit;
  assign busy         = busy_s;

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// Scoreboard bench for odd_issue_ctrl: predicted writebacks are queued at issue
// and matched against the DUT writeback stage every cycle.
module tb_odd_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_ready;
  logic [1:0] unit = 2'd0;
  logic [6:0] rt_addr = 7'd0;
  logic       reg_write = 1'b0;
  logic [6:0] ra_addr = 7'd0;
  logic [6:0] rb_addr = 7'd0;
  logic [6:0] rc_addr = 7'd0;
  logic [2:0] src_used = 3'd0;
  logic       perm_go, ls_go, br_go, wb_valid, reg_write_wb, illegal_op, busy;
  logic [6:0] rt_addr_wb;
  logic [1:0] wb_unit;

  typedef struct {
    int         wb;
    logic [6:0] rt;
    logic       rw;
    logic [1:0] u;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [3:0] pend_go = 4'b0;

`ifdef ODD_SCOREBOARD_EN
  localparam int EXP_RAW_STALL = 6;
`else
  localparam int EXP_RAW_STALL = 0;
`endif

  odd_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .unit         (unit),
    .rt_addr      (rt_addr),
    .reg_write    (reg_write),
    .ra_addr      (ra_addr),
    .rb_addr      (rb_addr),
    .rc_addr      (rc_addr),
    .src_used     (src_used),
    .perm_go      (perm_go),
    .ls_go        (ls_go),
    .br_go        (br_go),
    .wb_valid     (wb_valid),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb),
    .wb_unit      (wb_unit),
    .illegal_op   (illegal_op),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] u);
    case (u)
      2'd0:    return 4;
      2'd1:    return 6;
      2'd2:    return 2;
      default: return 0;
    endcase
  endfunction

  // Advance one cycle, then check go pulses, writeback stage and busy.
  task automatic tick();
    logic [3:0]  eg;
    logic [10:0] ew;
    eg = reset ? 4'b0 : pend_go;
    pend_go = 4'b0;
    if (reset) sb_q.delete();
    @(posedge clk);
    cyc++;
    #1;
    chk("go", 32'({perm_go, ls_go, br_go, illegal_op}), 32'(eg));
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].wb < cyc) sb_q.delete(i);
    end
    ew = 11'd0;
    foreach (sb_q[i]) begin
      if (sb_q[i].wb == cyc) ew = {1'b1, sb_q[i].rt, sb_q[i].rw, sb_q[i].u};
    end
    chk("wb", 32'({wb_valid, rt_addr_wb, reg_write_wb, wb_unit}), 32'(ew));
    chk("busy", 32'(busy), 32'(sb_q.size() > 0));
  endtask

  // Present one instruction for one cycle; the model predicts acceptance.
  task automatic try_issue(input logic [1:0] u, input logic [6:0] rt, input logic rw,
                           input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                           input logic [2:0] used, output logic acc);
    logic conf, haz;
    int   l;
    unit = u; rt_addr = rt; reg_write = rw;
    ra_addr = ra; rb_addr = rb; rc_addr = rc; src_used = used;
    issue_valid = 1'b1;
    #1;
    l = lat_of(u);
    conf = 1'b0;
    haz = 1'b0;
    foreach (sb_q[i]) begin
      if (sb_q[i].wb == cyc + l) conf = 1'b1;
      if (sb_q[i].rw && sb_q[i].wb >= cyc &&
          ((used[2] && sb_q[i].rt == ra) || (used[1] && sb_q[i].rt == rb) ||
           (used[0] && sb_q[i].rt == rc)))
        haz = 1'b1;
    end
`ifndef ODD_SCOREBOARD_EN
    haz = 1'b0;
`endif
    acc = (u == 2'd3) || (!conf && !haz);
    chk("ready", 32'(issue_ready), 32'(acc));
    if (acc) begin
      if (u == 2'd3) begin
        pend_go = 4'b0001;
      end else begin
        sb_q.push_back('{cyc + l, rt, rw, u});
        pend_go = 4'b1000 >> u;
      end
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic a;
    int   n;

    // Reset state.
    #1;
    chk("rst_ready", 32'(issue_ready), 32'd0);
    idle(2);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(issue_ready), 32'd1);

    // Single Perm to r5.
    try_issue(2'd0, 7'd5, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    chk("perm_acc", 32'(a), 32'd1);
    idle(6);

    // LS, then Br twice: the second Br collides with the LS writeback slot.
    try_issue(2'd1, 7'd10, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    idle(2);
    try_issue(2'd2, 7'd11, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    chk("br1_acc", 32'(a), 32'd1);
    try_issue(2'd2, 7'd12, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    chk("br2_slot_stall", 32'(a), 32'd0);
    try_issue(2'd2, 7'd12, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    chk("br2_retry_acc", 32'(a), 32'd1);
    idle(8);

    // RAW: Perm reads r9 produced by an LS.
    try_issue(2'd1, 7'd9, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    n = 0;
    do begin
      try_issue(2'd0, 7'd30, 1'b1, 7'd9, 7'd0, 7'd0, 3'b100, a);
      if (!a) n++;
    end while (!a && n < 20);
    chk("raw_stall", 32'(n), 32'(EXP_RAW_STALL));
    idle(6);

    // Undefined unit while a reservation is outstanding.
    try_issue(2'd1, 7'd40, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    try_issue(2'd3, 7'd41, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    chk("undef_acc", 32'(a), 32'd1);
    idle(7);

    // Reset with three Perms in flight.
    for (int i = 0; i < 3; i++) try_issue(2'd0, 7'(50 + i), 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, a);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(issue_ready), 32'd0);
    tick();
    reset = 1'b0;
    idle(5);

    // Non-writing Branch does not block a reader of its rt.
    try_issue(2'd2, 7'd20, 1'b0, 7'd0, 7'd0, 7'd0, 3'b000, a);
    try_issue(2'd0, 7'd21, 1'b1, 7'd20, 7'd0, 7'd0, 3'b100, a);
    chk("nowrite_no_stall", 32'(a), 32'd1);
    idle(6);

    // Random mix over a small register range.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        tick();
      end else begin
        try_issue(2'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), a);
      end
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_issue_ctrl.md
# odd_issue_ctrl

Issue controller for the odd pipeline (Permute, LocalStore, Branch units). Accepts one decoded odd-pipe instruction per cycle, fires the selected execution unit, and schedules every result into a unique writeback cycle using a reservation shift register. It also interlocks read-after-write hazards against in-flight destinations. Sits between decode/RF-fetch and the odd-pipe execution units, and drives the `rt_addr_wb`/`reg_write_wb` side of writeback.

## Interface
Parameters:
- `DEPTH`, 7: reservation slots; equals the writeback stage index.
- `PERM_LAT`, 4: Permute latency, issue to writeback.
- `LS_LAT`, 6: LocalStore latency.
- `BR_LAT`, 2: Branch latency.
- Constraint: all latencies lie in 1..DEPTH.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `issue_valid`  in  1: decoded instruction present.
- `issue_ready`  out  1: instruction accepted this cycle when both are high.
- `unit`  in  2: execution unit; 0 Perm, 1 LS, 2 Br, 3 undefined.
- `rt_addr`  in  7: destination register.
- `reg_write`  in  1: instruction writes `rt_addr`.
- `ra_addr`, `rb_addr`, `rc_addr`  in  7 each: source registers.
- `src_used`  in  3: per-source use flags {ra, rb, rc}.
- `perm_go`, `ls_go`, `br_go`  out  1 each: one-cycle unit start pulses.
- `wb_valid`  out  1: a result is in writeback this cycle.
- `rt_addr_wb`  out  7: destination of the writeback.
- `reg_write_wb`  out  1: writeback commits to the register table.
- `wb_unit`  out  2: source unit for the writeback mux.
- `illegal_op`  out  1: one-cycle pulse when a `unit==3` instruction is accepted.
- `busy`  out  1: at least one reservation is outstanding.

## Operation
- State: `res[1..DEPTH]`. Each entry holds {valid, rt_addr, reg_write, unit}. The index is the number of cycles until writeback.
- Every edge, each entry moves from `res[k]` to `res[k-1]`. The entry leaving `res[1]` drives the registered wb outputs.
- Latency for an instruction is L = the latency of its `unit`.
- Accept condition: `issue_ready` = not reset, and no slot conflict, and no hazard.
  - `issue_ready` is combinational on the current state and the issue inputs.
  - It is valid even when `issue_valid` is low.
- Slot conflict: after this edge's shift, `res[L]` would already be valid. Concretely, an earlier instruction already owns writeback cycle n+L.
- Hazard: any used source equals the `rt_addr` of a valid entry with `reg_write=1` whose writeback cycle is ≥ n. The current wb entry counts as a hazard; there is no bypass.
- On accept:
  - The entry is written to the slot that reaches writeback exactly L cycles later.
  - The matching `*_go` pulse is asserted in cycle n+1.
- `unit==3` on accept:
  - No reservation is made and no `*_go` fires.
  - `illegal_op` pulses in cycle n+1.
  - Hazard and slot checks are skipped; `issue_ready` is 1.
- `reg_write=0` instructions still reserve a slot: `wb_valid=1`, `reg_write_wb=0`.
- Only one issue is accepted per cycle. Entries retiring and a new issue in the same cycle never interact, because slots are distinct.
- A hazard stall holds until the producer has written back. The instruction is re-evaluated every cycle; the controller stores nothing for a stalled instruction.

## Timing
- Reset values: all `res` entries invalid. All outputs 0, except `issue_ready`, which evaluates to 0 during reset and 1 in the first cycle after it.
- Reset mid-operation discards all in-flight reservations. `wb_valid=0` from the cycle after reset is sampled; no late writebacks occur.
- Issue accepted in cycle n gives:
  - `*_go` in n+1.
  - `wb_valid`, `rt_addr_wb`, `reg_write_wb`, `wb_unit` in n+L, for exactly one cycle.
- `busy` is registered and high whenever any `res` entry is valid.
- Back-to-back issues to the same unit are always conflict-free.

## Configuration
- `ODD_SCOREBOARD_EN` defined: the RAW hazard interlock is active as described above.
- Undefined: the hazard term is forced to 0, and `issue_ready` depends only on slot conflicts (software-scheduled mode). The `src_used` and source address inputs are ignored.

## Structure
- Package `odd_ctrl_pkg`:
  - `unit_e` enum (PERM, LS, BR, UNDEF).
  - `resv_entry_t` struct.
  - Default latency localparams.
  - A `unit_lat()` function.
- Sub-module `odd_resv_shift`: the reservation shift register, with insert-at-index and an occupancy/match vector output. `odd_issue_ctrl` holds the accept logic and go/illegal pulses.

## Test plan
- Single Perm issue, rt=5, at cycle 10 → `perm_go` in 11; `wb_valid`, `rt_addr_wb=5`, `reg_write_wb=1`, `wb_unit=0` in 14 only; `busy` high in 11–14.
- LS issued at cycle 0, then Br at cycles 3 and 4 → Br at cycle 4 stalls (would write back in 6 with LS); accepted at 5 with writeback in 7.
- With scoreboard: LS writes r9 at cycle 0; Perm reading ra=r9 stalls in cycles 1–6 and is accepted at 7. Without the macro it is accepted at 1.
- `unit=3` issue → `illegal_op` pulse next cycle; no go pulse, no writeback, `busy` unchanged.
- Three Perm issues at cycles 0–2, reset asserted at cycle 3 → no `wb_valid` in cycles 4–6; `busy=0` at 4.
- `reg_write=0` Branch at cycle 0 → `wb_valid=1`, `reg_write_wb=0` in cycle 2; a following source read of the same `rt_addr` is not stalled.
